// File: rtl/divu_iter.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock,
// IDLE -> RUN (WIDTH cycles) -> DONE, with results held until the next completion.
module divu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is a request sampled only while IDLE; busy is high from the
  // accepting edge through the last RUN cycle; done is a one-cycle pulse in DONE.
  state_t state_q, state_d;

  logic [WIDTH-1:0] dq_q;   // dividend bits shift out of the MSB, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // When the divisor is non-zero the partial remainder stays below it, so the
  // top bit of the WIDTH+1-bit difference is a clean borrow. A zero divisor lets
  // the remainder grow, so a set shifted MSB also forces "greater or equal".
  always_comb begin
    shifted  = {rem_q, dq_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = shifted[WIDTH] | ~diff[WIDTH];
    rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {dq_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_q  <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dq_q  <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          dq_q  <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            q    <= quo_next;
            r    <= rem_next;
            dz   <= (dvs_q == '0);
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_divu_iter.sv
// Bench for divu_iter: directed corner cases, start/operand noise during RUN and
// DONE, mid-run reset, and a randomized regression against an arithmetic model.
module tb_divu_iter;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;
  logic [1:0]   dbg_state;

  int n_vec;
  int n_err;

  // Last completed result as the outputs must show it.
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_dz;

  divu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .q         (q),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned division; divide-by-zero gives all ones and the dividend.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
    if (b == '0) begin
      eq  = '1;
      er  = a;
      edz = 1'b1;
    end else begin
      eq  = a / b;
      er  = a % b;
      edz = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE->IDLE.
  // poke in 0..W-1 pulses start with new operands during RUN; poke == W pulses it in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    logic [W-1:0] eq, er;
    logic         edz;
    model(a, b, eq, er, edz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int k = 0; k < W; k++) begin
      chk($sformatf("busy_run[%0d]", k), W'(busy), W'(1'b1));
      chk($sformatf("done_run[%0d]", k), W'(done), W'(1'b0));
      chk("q_hold", q, prev_q);
      chk("r_hold", r, prev_r);
      chk("dz_hold", W'(dz), W'(prev_dz));
      start = (k == poke);
      if (k == poke) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
    end
    chk("done_pulse", W'(done), W'(1'b1));
    chk("busy_done", W'(busy), W'(1'b0));
    chk($sformatf("q(%0h/%0h)", a, b), q, eq);
    chk($sformatf("r(%0h/%0h)", a, b), r, er);
    chk("dz", W'(dz), W'(edz));
    start = (poke == W);
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", W'(done), W'(1'b0));
    chk("busy_idle", W'(busy), W'(1'b0));
    chk("q_after", q, eq);
    chk("r_after", r, er);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
  endtask

  initial begin
    logic [W-1:0] a, b;
    n_vec    = 0;
    n_err    = 0;
    prev_q   = '0;
    prev_r   = '0;
    prev_dz  = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q", q, '0);
    chk("rst_r", r, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_dz", W'(dz), '0);
    reset = 1'b1;
    @(negedge clk);

    // Directed corners, issued back to back
    run_op(32'd100, 32'd7, -1);
    chk("basic_q14", q, 32'd14);
    chk("basic_r2", r, 32'd2);
    run_op(32'hFFFF_FFFF, 32'd1, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(32'd5, 32'd0, -1);
    chk("dz_q_ones", q, 32'hFFFF_FFFF);
    run_op(32'd3, 32'd10, 10);
    run_op(32'd0, 32'd0, W);
    run_op(32'd0, 32'd5, 3);
    run_op(32'h8000_0000, 32'h8000_0001, W - 1);

    // Reset in the middle of a 1000/3 divide
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_q", q, '0);
    chk("mid_rst_r", r, '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_done", W'(done), '0);
    chk("mid_rst_dz", W'(dz), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_done", W'(done), '0);
      chk("rst_hold_busy", W'(busy), '0);
    end
    reset   = 1'b1;
    prev_q  = '0;
    prev_r  = '0;
    prev_dz = 1'b0;
    run_op(32'd1000, 32'd3, -1);
    chk("post_rst_q333", q, 32'd333);
    chk("post_rst_r1", r, 32'd1);

    // Randomized regression with biased corner operands
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 6))
        0:       begin a = $urandom; b = '0; end
        1:       begin a = '1; b = $urandom; end
        2:       begin a = $urandom; b = '1; end
        3:       begin a = $urandom; b = W'($urandom_range(1, 15)); end
        4:       begin a = W'($urandom_range(0, 255)); b = $urandom; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
